dmem_byte_ctrl: RTL and testbench

- Data-memory access engine directly downstream of the MIPS-lite datapath's memory stage.
- Accepts one 32-bit load/store request per handshake and serialises it into four big-endian byte accesses on an 8-bit synchronous RAM port.
- Byte at the word address holds bits [31:24]. Byte at address+3 holds bits [7:0].
- Lets the processor drop its combinational byte-array data memory in favour of a real single-port RAM macro.

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/dmem_byte_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_byte_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS-lite data-memory path.
//
// Contents:
//   state_e         - sequencing states of the byte-serial access engine
//   BYTES_PER_WORD  - bytes moved per 32-bit access
//   LAST_CNT        - byte counter value of the final byte of a word
//   byte_lane()     - big-endian byte select: lane 0 is bits [31:24], lane 3 is bits [7:0]
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  LAST_CNT       = 2'(BYTES_PER_WORD - 1);

    // Lane k sits at bit offset 8*(3-k); for a 2-bit k, (3-k) is simply ~k.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[{~k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dmem_byte_ctrl.sv
// Byte-serial data-memory access engine.
//
// Takes one 32-bit load/store per req handshake and turns it into four big-endian
// byte accesses on an 8-bit synchronous single-port RAM (1-cycle read latency).
// The byte at the word address carries bits [31:24]; address arithmetic wraps
// modulo 2^ADDR_W, so unaligned and wrapping words are legal.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we                1 = store word, 0 = load word
//   req_addr, req_wdata   byte address of the MSB byte, store data
//   rsp_valid             one-cycle completion pulse (loads and stores)
//   rsp_rdata             last completed load result, held between loads
//   mem_addr/we/wdata     registered RAM port
//   mem_rdata             RAM read byte, valid the cycle after its address
module dmem_byte_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    // Holds load bytes 0..2; byte 3 is merged straight from mem_rdata in DRAIN.
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    // Byte 0 goes onto the RAM port right away.
                    mem_addr_d  = req_addr;
                    mem_we_d    = req_we;
                    mem_wdata_d = byte_lane(req_wdata, 2'd0);
                    cnt_d       = 2'd0;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                // Read data trails the address by one cycle, so byte cnt-1 arrives now.
                if (!we_q && cnt_q != 2'd0) begin
                    asm_d = {asm_q[15:0], mem_rdata};
                end
                if (cnt_q == LAST_CNT) begin
                    mem_we_d = 1'b0;
                    state_d  = we_q ? RESP : DRAIN;
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    mem_addr_d  = addr_q + ADDR_W'(cnt_q + 2'd1);
                    mem_wdata_d = byte_lane(wdata_q, cnt_q + 2'd1);
                end
            end

            DRAIN: begin
                rdata_d = {asm_q, mem_rdata};
                state_d = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            asm_q       <= 24'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Self-checking bench for dmem_byte_ctrl: random and directed load/store traffic,
// a byte-array reference memory, and a queue-based response scoreboard.
module tb_dmem_byte_ctrl;

    localparam int unsigned AW    = 5;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    always #5 clk = ~clk;

    dmem_byte_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Byte RAM with 1-cycle read; seed port preloads contents during reset.
    logic [7:0]    ram [DEPTH];
    logic          seed_en = 1'b0;
    logic [AW-1:0] seed_addr = '0;
    logic [7:0]    seed_data = 8'd0;

    always @(posedge clk) begin
        if (seed_en) ram[seed_addr] <= seed_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int          due;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [7:0]    model [DEPTH];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_acc = 0;
    int            cyc = 0;
    int            busy_until = -1;
    int            last_acc_e = 0;
    logic          cur_act = 1'b0;
    logic          cur_we = 1'b0;
    int            cur_e = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [31:0]   cur_wdata = 32'd0;
    logic [31:0]   hold_exp = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_word(input logic [AW-1:0] a);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w = (w << 8) | 32'(model[(int'(a) + i) % DEPTH]);
        return w;
    endfunction

    // Monitor / scoreboard: samples on the falling edge, cycle index = rising edges so far.
    initial begin
        int   k;
        exp_t e;
        exp_t ne;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                busy_until = -1;
                cur_act    = 1'b0;
                hold_exp   = 32'd0;
            end else begin
                check("req_ready", 32'(req_ready), 32'(cyc > busy_until));
                k = cyc - cur_e - 1;
                if (cur_act && k >= 0 && k <= 3) begin
                    check("mem_we", 32'(mem_we), 32'(cur_we));
                    check("mem_addr", 32'(mem_addr), 32'((int'(cur_addr) + k) % DEPTH));
                    if (cur_we)
                        check("mem_wdata", 32'(mem_wdata), (cur_wdata >> (8 * (3 - k))) & 32'hFF);
                end else begin
                    check("mem_we_idle", 32'(mem_we), 32'd0);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_latency", 32'(cyc), 32'(e.due));
                        if (!e.we) hold_exp = e.data;
                        check(e.we ? "rsp_rdata_store" : "rsp_rdata_load", rsp_rdata, hold_exp);
                    end
                end else begin
                    if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                        check("rsp_missing", 32'd0, 32'd1);
                        void'(exp_q.pop_front());
                    end
                    check("rsp_rdata_hold", rsp_rdata, hold_exp);
                end
                // Handshake seen now is taken at the rising edge that ends this cycle.
                if (req_valid && req_ready) begin
                    cur_act    = 1'b1;
                    cur_e      = cyc;
                    cur_we     = req_we;
                    cur_addr   = req_addr;
                    cur_wdata  = req_wdata;
                    last_acc_e = cyc;
                    ne.we      = req_we;
                    if (req_we) begin
                        for (int i = 0; i < 4; i++)
                            model[(int'(req_addr) + i) % DEPTH] = 8'(req_wdata >> (8 * (3 - i)));
                        ne.data = 32'd0;
                        ne.due  = cyc + 5;
                    end else begin
                        ne.data = model_word(req_addr);
                        ne.due  = cyc + 6;
                    end
                    busy_until = ne.due;
                    exp_q.push_back(ne);
                    n_acc++;
                end
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic hold);
        int  start = n_acc;
        bit  got = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (n_acc != start) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          e1;
        logic [7:0]  b10;
        logic [7:0]  b11;

        for (int i = 0; i < DEPTH; i++) model[i] = 8'($urandom);

        #3;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            seed_en   = 1'b1;
            seed_addr = AW'(i);
            seed_data = model[i];
            @(posedge clk);
            #1;
        end
        seed_en = 1'b0;
        rst_n   = 1'b1;
        gap(2);

        // Directed: store/load, then a wrapping store/load.
        do_req(1'b1, 5'h04, 32'hDEADBEEF, 1'b0);
        gap(8);
        check("ram_04", 32'(ram[4]), 32'hDE);
        check("ram_05", 32'(ram[5]), 32'hAD);
        check("ram_06", 32'(ram[6]), 32'hBE);
        check("ram_07", 32'(ram[7]), 32'hEF);
        do_req(1'b0, 5'h04, 32'h0, 1'b0);
        gap(9);
        do_req(1'b1, 5'h1E, 32'h11223344, 1'b0);
        gap(8);
        check("ram_1e", 32'(ram[30]), 32'h11);
        check("ram_1f", 32'(ram[31]), 32'h22);
        check("ram_00", 32'(ram[0]), 32'h33);
        check("ram_01", 32'(ram[1]), 32'h44);
        do_req(1'b0, 5'h1E, 32'h0, 1'b0);
        gap(9);

        // Back-to-back with req_valid held: store then load.
        do_req(1'b1, AW'($urandom), $urandom, 1'b1);
        e1 = last_acc_e;
        do_req(1'b0, AW'($urandom), $urandom, 1'b0);
        check("b2b_store_spacing", 32'(last_acc_e - e1), 32'd6);
        gap(9);

        // Request held while a load is in progress.
        do_req(1'b0, AW'($urandom), $urandom, 1'b1);
        e1 = last_acc_e;
        do_req(1'b1, AW'($urandom), $urandom, 1'b0);
        check("b2b_load_spacing", 32'(last_acc_e - e1), 32'd7);
        gap(8);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            logic h;
            h = 1'($urandom);
            do_req(1'($urandom), AW'($urandom), $urandom, h);
            if (!h) gap($urandom_range(0, 3));
        end
        req_valid = 1'b0;
        gap(10);

        // Reset in the middle of a store, while byte 2 is on the port.
        b10 = model[10];
        b11 = model[11];
        do_req(1'b1, 5'h08, 32'hA1B2C3D4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model[10] = b10;
        model[11] = b11;
        check("midrst_ram_08", 32'(ram[8]), 32'hA1);
        check("midrst_ram_09", 32'(ram[9]), 32'hB2);
        check("midrst_ram_0a", 32'(ram[10]), 32'(b10));
        check("midrst_ram_0b", 32'(ram[11]), 32'(b11));
        gap(3);
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 5'h08, 32'h0, 1'b0);
        gap(10);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) check("ram_image", 32'(ram[i]), 32'(model[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
